// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store controller: funct3 encodings,
// memory width codes and FSM states.
package lsu_ctrl_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } lsu_state_e;

  // Bytes touched by an access of the given width (33 bits for the range check).
  function automatic logic [32:0] access_size(input logic [1:0] width);
    case (width)
      WIDTH_HALF: access_size = 33'd2;
      WIDTH_WORD: access_size = 33'd4;
      default:    access_size = 33'd1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Converts the memory's big-first read word into a little-endian,
// sign- or zero-extended load result.
module lsu_load_align
  import lsu_ctrl_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte0;
  logic [15:0] half0;
  logic [31:0] word0;

  // The byte at the requested address arrives in the top lane of mem_rdata.
  always_comb begin
    byte0 = mem_rdata[31:24];
    half0 = {mem_rdata[23:16], mem_rdata[31:24]};
    word0 = {mem_rdata[7:0], mem_rdata[15:8], mem_rdata[23:16], mem_rdata[31:24]};
    case (funct3)
      F3_LB:   result = {{24{byte0[7]}}, byte0};
      F3_LBU:  result = {24'd0, byte0};
      F3_LH:   result = {{16{half0[15]}}, half0};
      F3_LHU:  result = {16'd0, half0};
      default: result = word0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: one request at a time, alignment/range checks,
// a single-cycle memory access and a held response for writeback.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int ENTRIES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic        resp_fault,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_width,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  localparam logic [32:0] LIMIT = 33'(ENTRIES);

  lsu_state_e  state, state_next;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] rdata_q;
  logic        misaligned_q;
  logic        fault_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;

  logic [1:0]  req_width;
  logic        illegal;
  logic        misaligned;
  logic        out_of_range;
  logic        fault;
  logic [32:0] last_byte;
  logic [31:0] load_result;

  lsu_load_align u_align (
    .mem_rdata (mem_rdata),
    .funct3    (funct3_q),
    .result    (load_result)
  );

  // Request checks; last_byte is 33 bits so addresses near 2^32 cannot wrap.
  always_comb begin
    req_width    = req_funct3[1:0];
    illegal      = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                   (req_funct3 == 3'b111) || (req_we && req_funct3[2]);
    misaligned   = !illegal &&
                   (((req_width == WIDTH_HALF) && req_addr[0]) ||
                    ((req_width == WIDTH_WORD) && (req_addr[1:0] != 2'b00)));
    last_byte    = {1'b0, req_addr} + access_size(req_width) - 33'd1;
    out_of_range = !illegal && (last_byte >= LIMIT);
    fault        = illegal || out_of_range;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (req_valid) state_next = (misaligned || fault) ? ST_RESP : ST_ACCESS;
      ST_ACCESS: state_next = ST_RESP;
      ST_RESP:   if (resp_ready) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready       = (state == ST_IDLE);
    resp_valid      = (state == ST_RESP);
    resp_rdata      = rdata_q;
    resp_misaligned = misaligned_q;
    resp_fault      = fault_q;
    mem_addr        = mem_addr_q;
    mem_wdata       = mem_wdata_q;
    mem_write       = (state == ST_ACCESS) && we_q;
    mem_width       = (state == ST_ACCESS) ? funct3_q[1:0] : WIDTH_BYTE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Memory-facing address/data only move for requests that will really access memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      rdata_q      <= 32'd0;
      misaligned_q <= 1'b0;
      fault_q      <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            we_q         <= req_we;
            funct3_q     <= req_funct3;
            rdata_q      <= 32'd0;
            misaligned_q <= misaligned;
            fault_q      <= fault;
            if (!(misaligned || fault)) begin
              mem_addr_q  <= req_addr;
              mem_wdata_q <= req_wdata;
            end
          end
        end
        ST_ACCESS: begin
          if (!we_q) rdata_q <= load_result;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl with a small byte-array memory model.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic        resp_fault;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_width;
  logic        mem_write;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;
  logic [1:0] lastWriteWidth;

  logic [7:0] mem [0:1023];
  logic       memLoaded = 1'b0;

  always #5 clk = ~clk;

  lsu_ctrl #(.ENTRIES(1024)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_we          (req_we),
    .req_funct3      (req_funct3),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_rdata      (resp_rdata),
    .resp_misaligned (resp_misaligned),
    .resp_fault      (resp_fault),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_width       (mem_width),
    .mem_write       (mem_write),
    .mem_rdata       (mem_rdata)
  );

  // Preload on the first edge, then commit little-endian writes.
  always @(posedge clk) begin
    if (!memLoaded) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
      mem[10'h010] <= 8'h80;
      mem[10'h011] <= 8'h7F;
      mem[10'h012] <= 8'h01;
      mem[10'h013] <= 8'hFF;
      memLoaded <= 1'b1;
    end else if (mem_write) begin
      mem[mem_addr[9:0]] <= mem_wdata[7:0];
      if (mem_width != 2'b00) mem[mem_addr[9:0] + 10'd1] <= mem_wdata[15:8];
      if (mem_width == 2'b10) begin
        mem[mem_addr[9:0] + 10'd2] <= mem_wdata[23:16];
        mem[mem_addr[9:0] + 10'd3] <= mem_wdata[31:24];
      end
    end
  end

  always_comb begin
    mem_rdata = {mem[mem_addr[9:0]], mem[mem_addr[9:0] + 10'd1],
                 mem[mem_addr[9:0] + 10'd2], mem[mem_addr[9:0] + 10'd3]};
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge while IDLE; returns just after the accepting edge.
  task automatic applyStimulus(input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    checkOutput("req_ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic waitResp(input string tag, input int expLat, input logic [31:0] expRdata,
                          input logic expMis, input logic expFault, input int expWrites);
    int  lat = 0;
    int  writes = 0;
    bit  seen = 0;
    for (int i = 1; i <= 8 && !seen; i++) begin
      @(negedge clk);
      if (mem_write) begin
        writes++;
        lastWriteWidth = mem_width;
      end
      if (resp_valid) begin
        seen = 1;
        lat  = i;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $error("[TB] FAIL %s_timeout: observed=no resp_valid expected=resp_valid", tag);
    end else begin
      checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
      checkOutput({tag, "_rdata"}, resp_rdata, expRdata);
      checkOutput({tag, "_misaligned"}, {31'd0, resp_misaligned}, {31'd0, expMis});
      checkOutput({tag, "_fault"}, {31'd0, resp_fault}, {31'd0, expFault});
      checkOutput({tag, "_writes"}, 32'(writes), 32'(expWrites));
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0; lastWriteWidth = 2'b00;
    repeat (3) @(negedge clk);
    checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("rst_rdata", resp_rdata, 32'd0);
    checkOutput("rst_flags", {30'd0, resp_misaligned, resp_fault}, 32'd0);
    checkOutput("rst_mem_write", {31'd0, mem_write}, 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
    checkOutput("rst_mem_width", {30'd0, mem_width}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] loads from preloaded bytes 80 7F 01 FF");
    applyStimulus(1'b0, 3'b010, 32'h10, 32'h0); waitResp("lw_10",  2, 32'hFF017F80, 0, 0, 0);
    applyStimulus(1'b0, 3'b000, 32'h10, 32'h0); waitResp("lb_10",  2, 32'hFFFFFF80, 0, 0, 0);
    applyStimulus(1'b0, 3'b100, 32'h10, 32'h0); waitResp("lbu_10", 2, 32'h00000080, 0, 0, 0);
    applyStimulus(1'b0, 3'b001, 32'h12, 32'h0); waitResp("lh_12",  2, 32'hFFFFFF01, 0, 0, 0);
    applyStimulus(1'b0, 3'b101, 32'h12, 32'h0); waitResp("lhu_12", 2, 32'h0000FF01, 0, 0, 0);

    $display("[TB] store then load back");
    applyStimulus(1'b1, 3'b010, 32'h20, 32'hDEADBEEF); waitResp("sw_20", 2, 32'h0, 0, 0, 1);
    checkOutput("sw_20_width", {30'd0, lastWriteWidth}, 32'd2);
    applyStimulus(1'b0, 3'b010, 32'h20, 32'h0); waitResp("lw_20", 2, 32'hDEADBEEF, 0, 0, 0);

    $display("[TB] misaligned, range and illegal funct3");
    applyStimulus(1'b0, 3'b010, 32'h21, 32'h0);        waitResp("lw_21", 1, 32'h0, 1, 0, 0);
    applyStimulus(1'b1, 3'b000, 32'h3FF, 32'h000000A5); waitResp("sb_3ff", 2, 32'h0, 0, 0, 1);
    applyStimulus(1'b0, 3'b000, 32'h3FF, 32'h0);        waitResp("lb_3ff", 2, 32'hFFFFFFA5, 0, 0, 0);
    applyStimulus(1'b1, 3'b001, 32'h3FF, 32'h1234);     waitResp("sh_3ff", 1, 32'h0, 1, 1, 0);
    applyStimulus(1'b0, 3'b010, 32'h3FC, 32'h0);        waitResp("lw_3fc", 2, 32'hA5000000, 0, 0, 0);
    applyStimulus(1'b0, 3'b010, 32'h400, 32'h0);        waitResp("lw_400", 1, 32'h0, 0, 1, 0);
    applyStimulus(1'b0, 3'b000, 32'hFFFFFFFF, 32'h0);   waitResp("lb_top", 1, 32'h0, 0, 1, 0);
    applyStimulus(1'b0, 3'b011, 32'h10, 32'h0);         waitResp("f3_011", 1, 32'h0, 0, 1, 0);
    applyStimulus(1'b1, 3'b100, 32'h10, 32'h0);         waitResp("st_f3_100", 1, 32'h0, 0, 1, 0);

    $display("[TB] resp_ready already high when response appears");
    resp_ready = 1'b1;
    applyStimulus(1'b0, 3'b100, 32'h10, 32'h0); waitResp("lbu_fast", 2, 32'h00000080, 0, 0, 0);
    checkOutput("fast_resp_gone", {31'd0, resp_valid}, 32'd0);

    $display("[TB] response held while resp_ready low");
    applyStimulus(1'b0, 3'b010, 32'h10, 32'h0);
    repeat (2) @(negedge clk);
    checkOutput("hold_valid_rise", {31'd0, resp_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h20;
      @(negedge clk);
      checkOutput("hold_valid", {31'd0, resp_valid}, 32'd1);
      checkOutput("hold_rdata", resp_rdata, 32'hFF017F80);
      checkOutput("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    checkOutput("hold_release_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("hold_release_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    checkOutput("ignored_not_queued", {31'd0, resp_valid}, 32'd0);
    checkOutput("ignored_mem_addr", mem_addr, 32'h10);

    $display("[TB] reset during ACCESS");
    applyStimulus(1'b1, 3'b010, 32'h30, 32'h11223344);
    @(negedge clk);
    checkOutput("access_mem_write", {31'd0, mem_write}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_access_write", {31'd0, mem_write}, 32'd0);
    checkOutput("rst_access_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("rst_access_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("rst_access_width", {30'd0, mem_width}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_valid", {31'd0, resp_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
